clock_set_ctrl: RTL
===================

# clock_set_ctrl

Time-setting controller for the stopwatch/clock datapath. It consumes the single-cycle pulses from the per-button debouncers plus one raw button level for hold detection. It sequences a RUN / set-hours / set-minutes / set-seconds mode machine and issues one-cycle increment/clear strobes and a run enable to the timekeeping counters. It also generates the blink enable for the digit being edited, and an idle timeout returns it to RUN.

## Interface
- HOLD_CYCLES, 50_000_000: cycles inc_btn must stay high in SET_HR/SET_MIN before auto-repeat starts
- REPEAT_CYCLES, 10_000_000: cycles between auto-repeat strobes once repeating
- TIMEOUT_CYCLES, 500_000_000: cycles with no mode_p/inc_p in a set state before forced return to RUN
- BLINK_CYCLES, 12_500_000: half-period of blink in set states
- clk  in  1  system clock, one clock domain
- rst  in  1  synchronous, active-high reset
- mode_p  in  1  debounced single-cycle mode-button pulse
- inc_p  in  1  debounced single-cycle increment-button pulse
- inc_btn  in  1  raw asynchronous increment-button level, hold detection only
- run_en  out  1  timekeeping counters advance when 1
- hr_inc  out  1  one-cycle strobe: hours +1
- min_inc  out  1  one-cycle strobe: minutes +1
- sec_clr  out  1  one-cycle strobe: seconds cleared to 0
- sel  out  2  edited field: 0 none, 1 hours, 2 minutes, 3 seconds
- blink  out  1  blank selected digits when 1

## Operation
- States: RUN(0), SET_HR(1), SET_MIN(2), SET_SEC(3); sel mirrors state.
- mode_p advances the state: RUN->SET_HR->SET_MIN->SET_SEC->RUN.
- inc_p in SET_HR drives hr_inc, in SET_MIN min_inc, in SET_SEC sec_clr. It is ignored in RUN.
- mode_p and inc_p in the same cycle: mode wins, inc dropped, no strobe.
- run_en = 1 only in RUN. Counters are frozen while editing.
- inc_btn passes through a 2-flop synchronizer. The sync level only drives the repeat logic, never a strobe by itself.
- Auto-repeat, SET_HR/SET_MIN only:
  - A hold counter counts while the sync level is high and clears when it is low.
  - At HOLD_CYCLES the first repeat strobe fires.
  - After that, one strobe every REPEAT_CYCLES while held.
  - Any state change clears the hold and repeat counters.
- Timeout: the idle counter runs in set states and clears on mode_p, inc_p or any repeat strobe. At TIMEOUT_CYCLES it forces RUN, with no strobe that cycle.
- blink toggles every BLINK_CYCLES in set states. It is forced to 0 in RUN and restarts at 0 on every state change.
- Counter widths: $clog2(param+1). Counters saturate at their terminal value and never wrap.

## Timing
- All outputs are registered.
- A strobe asserts in the cycle after the triggering mode_p/inc_p/terminal count is sampled, and lasts exactly one cycle.
- A state change caused by mode_p is visible on sel/run_en one cycle after mode_p.
- Reset values: state RUN, run_en 1, sel 0, blink 0, all strobes 0, all counters 0, synchronizer 0.
- rst mid-edit: next cycle RUN with no strobe emitted.
- Strobe spacing:
  - Worst case between the last manual inc_p and the first repeat is HOLD_CYCLES + 2 (synchronizer latency).
  - An inc_p coinciding with a repeat strobe yields a single strobe, not two.

## Structure
- Package clock_set_pkg holds the state encodings (RUN/SET_HR/SET_MIN/SET_SEC) and the sel encoding, shared with the display mux.
- One sub-module, btn_repeat: synchronizer plus hold/repeat counters, with inputs clk, rst, btn, enable and output a one-cycle rpt_p. The controller ORs rpt_p with inc_p before strobe decode.

## Test plan
Bench parameters: HOLD_CYCLES=8, REPEAT_CYCLES=4, TIMEOUT_CYCLES=32, BLINK_CYCLES=3.
- Reset, then 3 mode_p pulses 5 cycles apart -> sel 1,2,3 each one cycle after its pulse; run_en 0 from the first pulse. A 4th pulse -> sel 0, run_en 1.
- In SET_MIN, inc_p twice -> exactly two one-cycle min_inc, each one cycle after its pulse; hr_inc and sec_clr stay 0.
- In SET_HR, hold inc_btn for 30 cycles -> first hr_inc about 10 cycles after the rise, then every 4 cycles; no hr_inc after release.
- In SET_SEC, no activity for 32 cycles -> back to RUN, run_en 1, blink 0, no sec_clr. Activity at cycle 31 restarts the count.
- mode_p and inc_p in the same cycle in SET_HR -> sel becomes 2, no hr_inc. rst asserted in SET_MIN -> sel 0, run_en 1 next cycle.
- blink in SET_HR toggles every 3 cycles. In RUN it stays 0; inc_p in RUN produces no strobe.

Source files
------------

// File: rtl/clock_set_pkg.sv
// Purpose: shared encodings for the time-setting controller and the display mux.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: state_t (mode machine), SEL_* (edited-field code), next_mode(), sel_of().
package clock_set_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_t;

  // Field selector seen by the display mux.
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HR   = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_SEC  = 2'd3;

  // Mode button cycles RUN -> HR -> MIN -> SEC -> RUN.
  function automatic state_t next_mode(input state_t s);
    case (s)
      ST_RUN:     return ST_SET_HR;
      ST_SET_HR:  return ST_SET_MIN;
      ST_SET_MIN: return ST_SET_SEC;
      default:    return ST_RUN;
    endcase
  endfunction

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      ST_SET_HR:  return SEL_HR;
      ST_SET_MIN: return SEL_MIN;
      ST_SET_SEC: return SEL_SEC;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Purpose: synchronise a raw button level and turn a long hold into periodic one-cycle pulses.
// Latency: first rpt_p HOLD_CYCLES+2 cycles after btn rises, then every REPEAT_CYCLES.
// Backpressure: none; enable low clears all hold/repeat progress immediately.
// Ports: clk, rst (sync, active-high), btn (raw async level), enable (repeat allowed), rpt_p (pulse out).
module btn_repeat #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic enable,
  output logic rpt_p
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_TERM = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rpt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      hold_cnt <= '0;
      rpt_cnt  <= '0;
      rpt_p    <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      rpt_p   <= 1'b0;
      if (!enable || !sync_q2) begin
        hold_cnt <= '0;
        rpt_cnt  <= '0;
      end else if (hold_cnt != HOLD_TERM) begin
        // Hold phase: first pulse on reaching the terminal count, which then sticks.
        hold_cnt <= hold_cnt + 1'b1;
        rpt_p    <= (hold_cnt == HOLD_LAST);
      end else if (rpt_cnt == RPT_LAST) begin
        // Repeat phase: restart the period counter on every pulse.
        rpt_cnt <= '0;
        rpt_p   <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Purpose: RUN/SET_HR/SET_MIN/SET_SEC mode machine issuing edit strobes, run enable and blink.
// Latency: every output registered; strobes and state changes appear one cycle after their trigger.
// Backpressure: none; mode_p beats a coincident inc_p/repeat, which is dropped.
// Ports: clk, rst (sync, active-high), mode_p/inc_p (debounced pulses), inc_btn (raw level),
//        run_en, hr_inc, min_inc, sec_clr (strobes), sel (edited field), blink.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int BLINK_CYCLES   = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_p,
  input  logic       inc_p,
  input  logic       inc_btn,
  output logic       run_en,
  output logic       hr_inc,
  output logic       min_inc,
  output logic       sec_clr,
  output logic [1:0] sel,
  output logic       blink
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_TERM  = TW'(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] idle_cnt;
  logic [BW-1:0] blink_cnt;
  logic          rpt_p;
  logic          rpt_en;
  logic          trig;
  logic          timeout_hit;
  logic          state_chg;
  logic          hr_d;
  logic          min_d;
  logic          sec_d;

  btn_repeat #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_btn_repeat (
    .clk    (clk),
    .rst    (rst),
    .btn    (inc_btn),
    .enable (rpt_en),
    .rpt_p  (rpt_p)
  );

  always_comb begin
    trig        = inc_p | rpt_p;
    // Any activity in the terminal cycle keeps us in the set state, so a
    // timeout never coincides with a strobe.
    timeout_hit = (state_q != ST_RUN) && !mode_p && !trig && (idle_cnt == IDLE_LAST);

    state_d = state_q;
    if (mode_p) begin
      state_d = next_mode(state_q);
    end else if (timeout_hit) begin
      state_d = ST_RUN;
    end
    state_chg = (state_d != state_q);

    hr_d  = !mode_p && trig  && (state_q == ST_SET_HR);
    min_d = !mode_p && trig  && (state_q == ST_SET_MIN);
    sec_d = !mode_p && inc_p && (state_q == ST_SET_SEC);

    // Dropping enable on the changing edge clears hold progress and any pending repeat.
    rpt_en = ((state_q == ST_SET_HR) || (state_q == ST_SET_MIN)) && !state_chg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      run_en    <= 1'b1;
      hr_inc    <= 1'b0;
      min_inc   <= 1'b0;
      sec_clr   <= 1'b0;
      blink     <= 1'b0;
      idle_cnt  <= '0;
      blink_cnt <= '0;
    end else begin
      state_q <= state_d;
      run_en  <= (state_d == ST_RUN);
      hr_inc  <= hr_d;
      min_inc <= min_d;
      sec_clr <= sec_d;

      if ((state_d == ST_RUN) || state_chg || trig) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_TERM) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if ((state_d == ST_RUN) || state_chg) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign sel = sel_of(state_q);

endmodule
